// File: rtl/controlador_bebida.sv
// Drink-dispensing controller driving the reservoir's Usar input: check water, preheat, pour a dose.
// Optional CONTADOR_BEBIDAS_EN adds a saturating 8-bit completed-drink counter on port Bebidas.
module controlador_bebida #(
  parameter int unsigned DOSE_CURTO   = 3,
  parameter int unsigned DOSE_LONGO   = 6,
  parameter int unsigned DOSE_AGUA    = 8,
  parameter int unsigned AQUEC_CICLOS = 2
) (
  input  logic       Clock,
  input  logic       ResetN,
  input  logic [1:0] Escolha,
  input  logic       Iniciar,
  input  logic       TemAgua,
  input  logic       HouveRefill,
  input  logic [3:0] TempoDeAgua,
  output logic       Usar,
  output logic       Ocupado,
  output logic       Pronto,
  output logic       Erro,
  output logic [3:0] Progresso
`ifdef CONTADOR_BEBIDAS_EN
  ,
  output logic [7:0] Bebidas
`endif
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_HEAT,
    S_POUR,
    S_DONE,
    S_ERROR
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] heat_q, heat_d;
  logic [CNT_W-1:0] prog_d;
  logic [CNT_W-1:0] dose_sel;

  // Dose lookup for the current selection
  always_comb begin
    dose_sel = '0;
    case (Escolha)
      2'd1:    dose_sel = CNT_W'(DOSE_CURTO);
      2'd2:    dose_sel = CNT_W'(DOSE_LONGO);
      2'd3:    dose_sel = CNT_W'(DOSE_AGUA);
      default: dose_sel = '0;
    endcase
  end

  // Next-state and counter update
  always_comb begin
    state_d = state_q;
    heat_d  = heat_q;
    prog_d  = Progresso;
    case (state_q)
      S_IDLE: begin
        if (Iniciar && (Escolha != 2'd0)) begin
          prog_d  = dose_sel;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (TemAgua && (TempoDeAgua >= Progresso)) begin
          heat_d  = CNT_W'(AQUEC_CICLOS);
          state_d = S_HEAT;
        end else begin
          state_d = S_ERROR;
        end
      end
      S_HEAT: begin
        if (heat_q != '0) heat_d = heat_q - CNT_W'(1);
        if (heat_q <= CNT_W'(1)) state_d = S_POUR;
      end
      S_POUR: begin
        // Losing water takes priority over completing the final decrement
        if (!TemAgua) begin
          state_d = S_ERROR;
        end else begin
          if (Progresso != '0) prog_d = Progresso - CNT_W'(1);
          if (Progresso <= CNT_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      S_ERROR: begin
        if (HouveRefill) begin
          prog_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and outputs registered; outputs decoded from the next state
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q   <= S_IDLE;
      heat_q    <= '0;
      Progresso <= '0;
      Usar      <= 1'b0;
      Ocupado   <= 1'b0;
      Pronto    <= 1'b0;
      Erro      <= 1'b0;
    end else begin
      state_q   <= state_d;
      heat_q    <= heat_d;
      Progresso <= prog_d;
      Usar      <= (state_d == S_POUR);
      Ocupado   <= (state_d != S_IDLE);
      Pronto    <= (state_d == S_DONE);
      Erro      <= (state_d == S_ERROR);
    end
  end

`ifdef CONTADOR_BEBIDAS_EN
  // Completed-drink counter, saturating at 255
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      Bebidas <= '0;
    end else if ((state_q == S_DONE) && (Bebidas != 8'hFF)) begin
      Bebidas <= Bebidas + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_controlador_bebida.sv
// Directed self-checking bench for controlador_bebida (default parameters).
module tb_controlador_bebida;

  logic       Clock = 1'b0;
  logic       ResetN;
  logic [1:0] Escolha;
  logic       Iniciar;
  logic       TemAgua;
  logic       HouveRefill;
  logic [3:0] TempoDeAgua;
  logic       Usar, Ocupado, Pronto, Erro;
  logic [3:0] Progresso;
`ifdef CONTADOR_BEBIDAS_EN
  logic [7:0] Bebidas;
`endif

  int n_checks = 0;
  int n_errors = 0;

  controlador_bebida dut (
    .Clock(Clock), .ResetN(ResetN), .Escolha(Escolha), .Iniciar(Iniciar),
    .TemAgua(TemAgua), .HouveRefill(HouveRefill), .TempoDeAgua(TempoDeAgua),
    .Usar(Usar), .Ocupado(Ocupado), .Pronto(Pronto), .Erro(Erro),
    .Progresso(Progresso)
`ifdef CONTADOR_BEBIDAS_EN
    , .Bebidas(Bebidas)
`endif
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Packed view {Ocupado, Usar, Pronto, Erro, Progresso}
  function automatic logic [7:0] obs();
    return {Ocupado, Usar, Pronto, Erro, Progresso};
  endfunction

  task automatic step();
    @(negedge Clock);
  endtask

  // Pulse Iniciar for one edge; returns at the negedge of the CHECK cycle
  task automatic start(input logic [1:0] esc);
    Escolha = esc;
    Iniciar = 1'b1;
    step();
    Iniciar = 1'b0;
  endtask

  task automatic wait_usar(input string tag);
    int n = 0;
    while (!Usar && n < 30) begin
      step();
      n++;
    end
    chk(tag, int'(Usar), 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (Ocupado && n < 40) begin
      step();
      n++;
    end
    chk(tag, int'(Ocupado), 0);
  endtask

  task automatic refill();
    HouveRefill = 1'b1;
    step();
    HouveRefill = 1'b0;
    TemAgua = 1'b1;
  endtask

  logic [7:0] short_exp [8];
  int usar_cnt, pronto_cnt, first_prog;

  initial begin
    short_exp[0] = 8'h83; // CHECK
    short_exp[1] = 8'h83; // HEAT
    short_exp[2] = 8'h83; // HEAT
    short_exp[3] = 8'hC3; // POUR 3
    short_exp[4] = 8'hC2; // POUR 2
    short_exp[5] = 8'hC1; // POUR 1
    short_exp[6] = 8'hA0; // DONE
    short_exp[7] = 8'h00; // IDLE

    ResetN = 1'b0; Iniciar = 1'b1; Escolha = 2'd2;
    TemAgua = 1'b1; HouveRefill = 1'b0; TempoDeAgua = 4'd9;
    step(); step();
    chk("reset_outputs", int'(obs()), 0);
    Iniciar = 1'b0;
    ResetN = 1'b1;
    step(); step(); step();
    chk("post_reset_idle", int'(obs()), 0);
`ifdef CONTADOR_BEBIDAS_EN
    chk("bebidas_reset", int'(Bebidas), 0);
`endif

    // Short coffee cycle-by-cycle
    start(2'd1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("short_cyc%0d", i), int'(obs()), int'(short_exp[i]));
      step();
    end

    // Long coffee with Iniciar/Escolha toggled during POUR
    start(2'd2);
    usar_cnt = 0; pronto_cnt = 0; first_prog = -1;
    for (int i = 0; i < 20 && Ocupado; i++) begin
      if (Usar) begin
        if (first_prog < 0) first_prog = int'(Progresso);
        usar_cnt++;
        Iniciar = ~Iniciar;
        Escolha = 2'd3;
      end else begin
        Iniciar = 1'b0;
      end
      if (Pronto) pronto_cnt++;
      step();
    end
    Iniciar = 1'b0;
    chk("long_usar_len", usar_cnt, 6);
    chk("long_first_prog", first_prog, 6);
    chk("long_pronto_cnt", pronto_cnt, 1);
    chk("long_back_idle", int'(Ocupado), 0);

    // Insufficient water: dose 6 against 5
    TempoDeAgua = 4'd5;
    start(2'd2);
    chk("insuf_check", int'(obs()), 8'h86);
    step();
    chk("insuf_error", int'(obs()), 8'h96);
    step(); step();
    chk("insuf_hold", int'(obs()), 8'h96);
    refill();
    chk("insuf_refill_idle", int'(obs()), 0);

    // Boundary: remaining water equals dose proceeds
    TempoDeAgua = 4'd3;
    start(2'd1);
    step();
    chk("equal_water_heat", int'(obs()), 8'h83);
    wait_idle("equal_water_done");

    // No water at CHECK
    TemAgua = 1'b0; TempoDeAgua = 4'd9;
    start(2'd1);
    step();
    chk("nowater_error", int'(Erro), 1);
    refill();
    chk("nowater_refill", int'(obs()), 0);

    // Water lost mid-pour: hot water, fails with 4 remaining
    TempoDeAgua = 4'd15;
    start(2'd3);
    wait_usar("lost_wait_usar");
    chk("lost_first_prog", int'(Progresso), 8);
    step(); step(); step(); step();
    chk("lost_prog4_pour", int'(obs()), 8'hC4);
    TemAgua = 1'b0;
    step();
    chk("lost_error", int'(obs()), 8'h94);
    pronto_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (Pronto || Usar) pronto_cnt++;
    end
    chk("lost_no_pronto_usar", pronto_cnt, 0);
    refill();
    chk("lost_refill_idle", int'(obs()), 0);

    // Water lost on the final-decrement edge: ERROR wins
    start(2'd1);
    wait_usar("last_wait_usar");
    step(); step();
    chk("last_prog1", int'(obs()), 8'hC1);
    TemAgua = 1'b0;
    step();
    chk("last_error_wins", int'(obs()), 8'h91);
    refill();

    // Escolha=0 with Iniciar ignored
    Escolha = 2'd0; Iniciar = 1'b1;
    step(); step(); step();
    Iniciar = 1'b0;
    chk("sel0_ignored", int'(obs()), 0);

    // Asynchronous reset mid-pour drops Usar without a clock edge
    start(2'd2);
    wait_usar("areset_wait_usar");
    ResetN = 1'b0;
    #1;
    chk("areset_usar", int'(Usar), 0);
    chk("areset_all", int'(obs()), 0);
    step();
    ResetN = 1'b1;
    step();

`ifdef CONTADOR_BEBIDAS_EN
    chk("bebidas_after_reset", int'(Bebidas), 0);
    for (int i = 0; i < 3; i++) begin
      start(2'(i + 1));
      wait_idle("cnt_drink");
    end
    TempoDeAgua = 4'd2;
    start(2'd2);
    step();
    refill();
    TempoDeAgua = 4'd15;
    chk("bebidas_three", int'(Bebidas), 3);
    for (int i = 0; i < 253; i++) begin
      start(2'd1);
      wait_idle("sat_drink");
    end
    chk("bebidas_256_sat", int'(Bebidas), 255);
    start(2'd1);
    wait_idle("sat_extra");
    chk("bebidas_hold", int'(Bebidas), 255);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
